// File: rtl/cdb_arb_if.sv
// Completion bus between the functional units and the CDB arbiter.
// master: functional-unit side (drives completions and flush)
// slave:  arbiter side (drives stalls, CDB broadcast and overflow flag)
// Tag and ROB index widths come from `PRF_IDX_W / `ROB_IDX_W.

`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

interface cdb_arb_if #(
  parameter int DATA_W = 64
);
  logic                  flush_i;
  logic                  alu_done_i;
  logic [`PRF_IDX_W-1:0] alu_tag_i;
  logic [DATA_W-1:0]     alu_value_i;
  logic [`ROB_IDX_W-1:0] alu_rob_idx_i;
  logic                  mult_done_i;
  logic [`PRF_IDX_W-1:0] mult_tag_i;
  logic [DATA_W-1:0]     mult_value_i;
  logic [`ROB_IDX_W-1:0] mult_rob_idx_i;
  logic                  alu_stall_o;
  logic                  mult_stall_o;
  logic                  cdb_vld_o;
  logic [`PRF_IDX_W-1:0] cdb_tag_o;
  logic [DATA_W-1:0]     cdb_value_o;
  logic [`ROB_IDX_W-1:0] cdb_rob_idx_o;
  logic                  ovf_err_o;

  modport master (
    output flush_i,
    output alu_done_i, alu_tag_i, alu_value_i, alu_rob_idx_i,
    output mult_done_i, mult_tag_i, mult_value_i, mult_rob_idx_i,
    input  alu_stall_o, mult_stall_o,
    input  cdb_vld_o, cdb_tag_o, cdb_value_o, cdb_rob_idx_o,
    input  ovf_err_o
  );

  modport slave (
    input  flush_i,
    input  alu_done_i, alu_tag_i, alu_value_i, alu_rob_idx_i,
    input  mult_done_i, mult_tag_i, mult_value_i, mult_rob_idx_i,
    output alu_stall_o, mult_stall_o,
    output cdb_vld_o, cdb_tag_o, cdb_value_o, cdb_rob_idx_o,
    output ovf_err_o
  );
endinterface

// File: rtl/cdb_arb.sv
// cdb_arb: completion arbiter feeding the CDB, PRF write port and ROB done port.
// Each source (ALU = 0, multiplier = 1) has its own circular queue; one result
// per cycle is granted round-robin and registered onto the broadcast outputs.
// Optional feature macro: CDB_ARB_BYPASS_EN lets a completion arriving at an
// empty queue compete in the same cycle (1-cycle latency instead of 2).

`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef ZERO_REG
`define ZERO_REG {`PRF_IDX_W{1'b0}}
`endif

module cdb_arb #(
  parameter int QDEPTH = 4,
  parameter int DATA_W = 64
) (
  input  logic      clk,
  input  logic      rst,
  cdb_arb_if.slave  bus
);
  localparam int IDX_W = $clog2(QDEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int TAG_W = `PRF_IDX_W;
  localparam int ROB_W = `ROB_IDX_W;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MULT = 1'b1} src_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  entry_t           mem     [2][QDEPTH];
  logic [PTR_W-1:0] rd_ptr  [2];
  logic [PTR_W-1:0] wr_ptr  [2];
  logic [PTR_W-1:0] count   [2];
  entry_t           in_ent  [2];
  entry_t           cand    [2];
  entry_t           win_ent;
  logic [1:0]       done;
  logic [1:0]       empty;
  logic [1:0]       full;
  logic [1:0]       cand_vld;
  logic [1:0]       granted;
  logic [1:0]       pop;
  logic [1:0]       push;
  logic [1:0]       drop;
  logic             grant;
  src_e             winner;
  src_e             rr_last;

  // Per-source queue status and arbitration candidates (queue head first, so
  // results from one source always leave in order)
  always_comb begin
    done      = {bus.mult_done_i, bus.alu_done_i};
    in_ent[0] = {bus.alu_tag_i, bus.alu_value_i, bus.alu_rob_idx_i};
    in_ent[1] = {bus.mult_tag_i, bus.mult_value_i, bus.mult_rob_idx_i};
    for (int s = 0; s < 2; s++) begin
      count[s] = wr_ptr[s] - rd_ptr[s];
      empty[s] = (count[s] == '0);
      full[s]  = (count[s] == PTR_W'(QDEPTH));
`ifdef CDB_ARB_BYPASS_EN
      cand_vld[s] = !empty[s] || done[s];
      cand[s]     = empty[s] ? in_ent[s] : mem[s][rd_ptr[s][IDX_W-1:0]];
`else
      cand_vld[s] = !empty[s];
      cand[s]     = mem[s][rd_ptr[s][IDX_W-1:0]];
`endif
    end
  end

  // Round-robin grant: on contention the source that did not win last time goes;
  // flush suppresses any grant so nothing stale reaches the CDB
  always_comb begin
    grant  = !bus.flush_i && (|cand_vld);
    winner = SRC_ALU;
    if (&cand_vld)
      winner = (rr_last == SRC_ALU) ? SRC_MULT : SRC_ALU;
    else if (cand_vld[1])
      winner = SRC_MULT;
    win_ent    = (winner == SRC_MULT) ? cand[1] : cand[0];
    granted[0] = grant && (winner == SRC_ALU);
    granted[1] = grant && (winner == SRC_MULT);
  end

  // Queue update decisions: a bypass-granted done is never also queued, and a
  // done at a full queue is only accepted when the head leaves the same cycle
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      pop[s]  = granted[s] && !empty[s];
      push[s] = !bus.flush_i && done[s] && !(granted[s] && empty[s]) &&
                (!full[s] || pop[s]);
      drop[s] = !bus.flush_i && done[s] && full[s] && !pop[s];
    end
  end

  // Queue pointers; flush returns both queues to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
      end
    end else if (bus.flush_i) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (pop[s])
          rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
        if (push[s])
          wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
      end
    end
  end

  // Queue storage; contents need no reset because the pointers gate validity
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s])
        mem[s][wr_ptr[s][IDX_W-1:0]] <= in_ent[s];
    end
  end

  // Registered broadcast, round-robin history and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cdb_vld_o     <= 1'b0;
      bus.cdb_tag_o     <= `ZERO_REG;
      bus.cdb_value_o   <= '0;
      bus.cdb_rob_idx_o <= '0;
      bus.ovf_err_o     <= 1'b0;
      rr_last           <= SRC_ALU;
    end else begin
      bus.ovf_err_o <= bus.ovf_err_o | (|drop);
      if (grant) begin
        bus.cdb_vld_o     <= 1'b1;
        bus.cdb_tag_o     <= win_ent.tag;
        bus.cdb_value_o   <= win_ent.value;
        bus.cdb_rob_idx_o <= win_ent.rob;
        rr_last           <= winner;
      end else begin
        bus.cdb_vld_o     <= 1'b0;
        bus.cdb_tag_o     <= `ZERO_REG;
        bus.cdb_value_o   <= '0;
        bus.cdb_rob_idx_o <= '0;
      end
    end
  end

  assign bus.alu_stall_o  = full[0];
  assign bus.mult_stall_o = full[1];

endmodule

// File: tb/tb_cdb_arb.sv
// Self-checking bench for cdb_arb: scoreboard queues per source are filled as
// completions are driven and drained as results appear on the CDB.

`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif

module tb_cdb_arb;
  localparam int DATA_W = 64;
  localparam int TAG_W  = `PRF_IDX_W;
  localparam int ROB_W  = `ROB_IDX_W;
`ifdef CDB_ARB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [TAG_W-1:0] DROP_TAG = TAG_W'(63);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
    logic [ROB_W-1:0]  rob;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arb_if #(.DATA_W(DATA_W)) bus ();

  cdb_arb #(.QDEPTH(4), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t alu_q[$];
  exp_t mult_q[$];
  exp_t mon_got, exp_a, exp_m;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   last_src  = -1;
  int   same_src_cnt = 0;
  int   drop_seen = 0;
  int   vld_seen  = 0;
  int   mon_src;

  // Scoreboard monitor: every broadcast must match the head of one source queue
  always @(negedge clk) begin
    if (!rst && bus.cdb_vld_o) begin
      mon_got = {bus.cdb_tag_o, bus.cdb_value_o, bus.cdb_rob_idx_o};
      vld_seen++;
      if (bus.cdb_tag_o == DROP_TAG) drop_seen++;
      total_cnt++;
      if (alu_q.size() > 0 && alu_q[0] === mon_got) begin
        void'(alu_q.pop_front());
        pass_cnt++;
        mon_src = 0;
      end else if (mult_q.size() > 0 && mult_q[0] === mon_got) begin
        void'(mult_q.pop_front());
        pass_cnt++;
        mon_src = 1;
      end else begin
        exp_a = (alu_q.size() > 0) ? alu_q[0] : '0;
        exp_m = (mult_q.size() > 0) ? mult_q[0] : '0;
        $display("[TB] FAIL scoreboard: got tag=%0d value=%h rob=%0d, required alu head tag=%0d value=%h rob=%0d (pending %0d) or mult head tag=%0d value=%h rob=%0d (pending %0d)",
                 mon_got.tag, mon_got.value, mon_got.rob, exp_a.tag, exp_a.value, exp_a.rob,
                 alu_q.size(), exp_m.tag, exp_m.value, exp_m.rob, mult_q.size());
        mon_src = -1;
      end
      if (mon_src >= 0 && mon_src == last_src) same_src_cnt++;
      last_src = mon_src;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    bus.flush_i        = 1'b0;
    bus.alu_done_i     = 1'b0;
    bus.alu_tag_i      = '0;
    bus.alu_value_i    = '0;
    bus.alu_rob_idx_i  = '0;
    bus.mult_done_i    = 1'b0;
    bus.mult_tag_i     = '0;
    bus.mult_value_i   = '0;
    bus.mult_rob_idx_i = '0;
  endtask

  task automatic drive_alu(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                           input logic [ROB_W-1:0] r, input bit track);
    bus.alu_done_i    = 1'b1;
    bus.alu_tag_i     = t;
    bus.alu_value_i   = v;
    bus.alu_rob_idx_i = r;
    if (track) alu_q.push_back({t, v, r});
  endtask

  task automatic drive_mult(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v,
                            input logic [ROB_W-1:0] r, input bit track);
    bus.mult_done_i    = 1'b1;
    bus.mult_tag_i     = t;
    bus.mult_value_i   = v;
    bus.mult_rob_idx_i = r;
    if (track) mult_q.push_back({t, v, r});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    total_cnt++; if (bus.cdb_vld_o !== 1'b0) $display("[TB] FAIL reset_vld: got %b, expected 0", bus.cdb_vld_o); else pass_cnt++;
    total_cnt++; if (bus.cdb_tag_o !== '0) $display("[TB] FAIL reset_tag: got %0d, expected 0", bus.cdb_tag_o); else pass_cnt++;
    total_cnt++; if (bus.cdb_value_o !== '0) $display("[TB] FAIL reset_value: got %h, expected 0", bus.cdb_value_o); else pass_cnt++;
    total_cnt++; if (bus.cdb_rob_idx_o !== '0) $display("[TB] FAIL reset_rob: got %0d, expected 0", bus.cdb_rob_idx_o); else pass_cnt++;
    total_cnt++; if ({bus.alu_stall_o, bus.mult_stall_o, bus.ovf_err_o} !== 3'b000)
      $display("[TB] FAIL reset_flags: got stall/stall/ovf %b, expected 000", {bus.alu_stall_o, bus.mult_stall_o, bus.ovf_err_o});
    else pass_cnt++;
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    int lat = 0;
    logic [TAG_W-1:0]  t = '0;
    logic [DATA_W-1:0] v = '0;
    logic [ROB_W-1:0]  r = '0;
    @(negedge clk); #1;
    drive_alu(TAG_W'(5), 64'h1234, ROB_W'(7), 1'b1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (lat == 0 && bus.cdb_vld_o) begin
        lat = i; t = bus.cdb_tag_o; v = bus.cdb_value_o; r = bus.cdb_rob_idx_o;
      end
      #1;
      if (i == 1) clear_inputs();
    end
    total_cnt++; if (lat !== LAT) $display("[TB] FAIL single_latency: got %0d cycles, expected %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (t !== TAG_W'(5)) $display("[TB] FAIL single_tag: got %0d, expected 5", t); else pass_cnt++;
    total_cnt++; if (v !== 64'h1234) $display("[TB] FAIL single_value: got %h, expected 1234", v); else pass_cnt++;
    total_cnt++; if (r !== ROB_W'(7)) $display("[TB] FAIL single_rob: got %0d, expected 7", r); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int seen [0:7];
    int first = 0;
    @(negedge clk); #1;
    drive_alu(TAG_W'(3), 64'h3333, ROB_W'(1), 1'b1);
    drive_mult(TAG_W'(9), 64'h9999, ROB_W'(2), 1'b1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      seen[i] = bus.cdb_vld_o ? int'(bus.cdb_tag_o) : -1;
      if (first == 0 && bus.cdb_vld_o) first = i;
      #1;
      if (i == 1) clear_inputs();
    end
    total_cnt++; if (first !== LAT) $display("[TB] FAIL simul_first_latency: got %0d, expected %0d", first, LAT); else pass_cnt++;
    total_cnt++; if (seen[LAT] !== 9) $display("[TB] FAIL simul_first_tag: got %0d, expected 9", seen[LAT]); else pass_cnt++;
    total_cnt++; if (seen[LAT+1] !== 3) $display("[TB] FAIL simul_second_tag: got %0d, expected 3", seen[LAT+1]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit stall_seen = 0;
    last_src = -1;
    same_src_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (bus.alu_stall_o || bus.mult_stall_o) stall_seen = 1;
      bus.alu_done_i = 1'b0;
      bus.mult_done_i = 1'b0;
      if (!bus.alu_stall_o)  drive_alu(TAG_W'(16 + c), 64'hA000 + 64'(c), ROB_W'(c), 1'b1);
      if (!bus.mult_stall_o) drive_mult(TAG_W'(40 + c), 64'hB000 + 64'(c), ROB_W'(8 + c), 1'b1);
    end
    @(negedge clk); #1;
    if (bus.alu_stall_o || bus.mult_stall_o) stall_seen = 1;
    clear_inputs();
    for (int c = 0; c < 40 && (alu_q.size() + mult_q.size()) > 0; c++) @(negedge clk);
    #1;
    total_cnt++; if (stall_seen !== 1'b1) $display("[TB] FAIL burst_stall: got %b, expected 1", stall_seen); else pass_cnt++;
    total_cnt++; if (same_src_cnt !== 0) $display("[TB] FAIL burst_alternate: got %0d repeated grants, expected 0", same_src_cnt); else pass_cnt++;
    total_cnt++; if (bus.ovf_err_o !== 1'b0) $display("[TB] FAIL burst_ovf: got %b, expected 0", bus.ovf_err_o); else pass_cnt++;
    total_cnt++; if (alu_q.size() + mult_q.size() !== 0)
      $display("[TB] FAIL burst_drain: got %0d results outstanding, expected 0", alu_q.size() + mult_q.size());
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit fired = 0;
    bit filled = 0;
    drop_seen = 0;
    for (int c = 0; c < 40 && !fired; c++) begin
      @(negedge clk); #1;
      bus.alu_done_i = 1'b0;
      bus.mult_done_i = 1'b0;
      if (bus.alu_stall_o) filled = 1;
      if (!bus.mult_stall_o) drive_mult(TAG_W'(32 + (c % 24)), 64'hC000 + 64'(c), ROB_W'(c % 32), 1'b1);
      if (!filled)
        drive_alu(TAG_W'(1 + c), 64'hD000 + 64'(c), ROB_W'(c % 32), 1'b1);
      else if (bus.alu_stall_o && bus.cdb_vld_o && last_src == 0) begin
        drive_alu(DROP_TAG, 64'hDEAD, ROB_W'(0), 1'b0);
        fired = 1;
      end else if (!bus.alu_stall_o || (bus.cdb_vld_o && last_src == 1))
        drive_alu(TAG_W'(1 + c), 64'hD000 + 64'(c), ROB_W'(c % 32), 1'b1);
    end
    total_cnt++; if (fired !== 1'b1) $display("[TB] FAIL ovf_setup: got %b, expected stalled full queue reached", fired); else pass_cnt++;
    @(negedge clk); #1;
    clear_inputs();
    total_cnt++; if (bus.ovf_err_o !== 1'b1) $display("[TB] FAIL ovf_set: got %b, expected 1", bus.ovf_err_o); else pass_cnt++;
    for (int c = 0; c < 40 && (alu_q.size() + mult_q.size()) > 0; c++) @(negedge clk);
    #1;
    total_cnt++; if (drop_seen !== 0) $display("[TB] FAIL ovf_drop_tag: got %0d broadcasts, expected 0", drop_seen); else pass_cnt++;
    total_cnt++; if (alu_q.size() + mult_q.size() !== 0)
      $display("[TB] FAIL ovf_drain: got %0d results outstanding, expected 0", alu_q.size() + mult_q.size());
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int lat = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      drive_alu(TAG_W'(20 + c), 64'hE000 + 64'(c), ROB_W'(c), 1'b1);
      drive_mult(TAG_W'(44 + c), 64'hF000 + 64'(c), ROB_W'(4 + c), 1'b1);
    end
    @(negedge clk); #1;
    bus.mult_done_i = 1'b0;
    drive_alu(TAG_W'(30), 64'hBAD0, ROB_W'(9), 1'b0);
    bus.flush_i = 1'b1;
    alu_q.delete();
    mult_q.delete();
    vld_seen = 0;
    @(negedge clk);
    total_cnt++; if (bus.cdb_vld_o !== 1'b0) $display("[TB] FAIL flush_vld: got %b, expected 0", bus.cdb_vld_o); else pass_cnt++;
    #1;
    clear_inputs();
    repeat (6) @(negedge clk);
    #1;
    total_cnt++; if (vld_seen !== 0) $display("[TB] FAIL flush_stale: got %0d broadcasts, expected 0", vld_seen); else pass_cnt++;
    total_cnt++; if (bus.ovf_err_o !== 1'b1) $display("[TB] FAIL flush_ovf_kept: got %b, expected 1", bus.ovf_err_o); else pass_cnt++;
    drive_alu(TAG_W'(17), 64'h7777, ROB_W'(3), 1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (lat == 0 && bus.cdb_vld_o) lat = i;
      #1;
      if (i == 1) clear_inputs();
    end
    total_cnt++; if (lat !== LAT) $display("[TB] FAIL flush_empty_latency: got %0d, expected %0d", lat, LAT); else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      bus.alu_done_i = 1'b0;
      bus.mult_done_i = 1'b0;
      if (!bus.alu_stall_o)  drive_alu(TAG_W'(8 + c), 64'h5000 + 64'(c), ROB_W'(c), 1'b1);
      if (!bus.mult_stall_o) drive_mult(TAG_W'(48 + c), 64'h6000 + 64'(c), ROB_W'(10 + c), 1'b1);
    end
    @(negedge clk); #1;
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    total_cnt++; if ({bus.cdb_vld_o, bus.ovf_err_o, bus.alu_stall_o, bus.mult_stall_o} !== 4'b0000)
      $display("[TB] FAIL midreset_flags: got vld/ovf/stall/stall %b, expected 0000",
               {bus.cdb_vld_o, bus.ovf_err_o, bus.alu_stall_o, bus.mult_stall_o});
    else pass_cnt++;
    total_cnt++; if ({bus.cdb_tag_o, bus.cdb_value_o, bus.cdb_rob_idx_o} !== '0)
      $display("[TB] FAIL midreset_bus: got tag %0d value %h rob %0d, expected 0 0 0",
               bus.cdb_tag_o, bus.cdb_value_o, bus.cdb_rob_idx_o);
    else pass_cnt++;
    alu_q.delete();
    mult_q.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    vld_seen = 0;
    repeat (6) @(negedge clk);
    #1;
    total_cnt++; if (vld_seen !== 0) $display("[TB] FAIL midreset_empty: got %0d broadcasts, expected 0", vld_seen); else pass_cnt++;
  endtask

  // Test sequence
  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
